scanline_proc: RTL and testbench
================================

Name: scanline_proc

Overview:
- Post-processing stage directly downstream of the scan converter, in the PCLK_OUT domain.
- Consumes the converter's RGB, HSYNC, VSYNC and DE and the shared sl_config/sl_config2 words.
- Darkens selected output lines and/or columns to emulate CRT scanlines and aperture mask, then forwards pixels and syncs to the output transmitter with a fixed 3-cycle latency.

Parameters:
- PIX_W, 8, bits per colour channel; 8 is the only supported value.

Ports:
- PCLK_i  in  1  output pixel clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- R_i, G_i, B_i  in  8 each  pixel data from the scan converter.
- HSYNC_i  in  1  active-low horizontal sync.
- VSYNC_i  in  1  active-low vertical sync.
- DE_i  in  1  active-high data enable.
- sl_config  in  32  [7:0] SL_STR strength, [15:8] SL_HMASK (bit n darkens line n of group), [18:16] SL_VPER_M1 line-group length-1, [19] SL_H_EN, [20] SL_V_EN.
- sl_config2  in  32  [7:0] SL_VMASK (bit n darkens column n of group), [10:8] SL_HPER_M1 column-group length-1.
- R_o, G_o, B_o  out  8 each  processed pixel data.
- HSYNC_o, VSYNC_o, DE_o  out  1 each  syncs delayed to match the data.

Behaviour:
- Reset: all registers clear asynchronously.
  - R_o/G_o/B_o = 0, DE_o = 0, HSYNC_o = 1, VSYNC_o = 1.
  - Shadow config = 0, i.e. scanlines off.
- Config shadowing: sl_config and sl_config2 are copied into shadow registers on the cycle VSYNC_i falls (VSYNC_i=0 while previous sample=1). All processing uses the shadow copy, so a mid-frame write never tears.
- Frame start, same VSYNC falling-edge cycle: set first_line flag.
- Line index y_idx (3 bits) updates on each DE rising edge (DE_i=1 while previous sample=0):
  - if first_line: y_idx = 0 and first_line clears;
  - else if y_idx == SL_VPER_M1: y_idx = 0;
  - else y_idx + 1.
  - If SL_VPER_M1 shrinks below the current y_idx, the next DE rise wraps y_idx to 0.
- Column index x_idx (3 bits):
  - 0 on the DE rising-edge pixel;
  - increments on every following DE=1 cycle, wrapping after SL_HPER_M1;
  - holds while DE=0.
- Darken decision, stage 1, registered: sl_on = DE_i & ((SL_H_EN & SL_HMASK[y_idx_eff]) | (SL_V_EN & SL_VMASK[x_idx_eff])).
  - y_idx_eff and x_idx_eff are the values that apply to the current pixel, including the edge pixel itself.
  - RGB and syncs are registered alongside.
- Blend, stage 2: per channel p = c * (sl_on ? 256 - SL_STR : 256), a 17-bit product.
- Output, stage 3: R_o etc. = p[15:8].
  - SL_STR = 0 gives out = in; SL_STR = 255 gives out = in >> 8 = 0.
  - 8-bit results never overflow.
- Latency: exactly 3 PCLK_i cycles from every input to the matching output, identical for data, HSYNC, VSYNC and DE.
  - When DE is low, RGB passes through the same path (sl_on = 0), so blanking data is preserved.
- Simultaneous events:
  - VSYNC fall and DE rise in the same cycle: the shadow load takes effect next cycle, and that line counts as first_line (y_idx = 0).
  - DE rise without a preceding VSYNC fall after reset: first_line is 0, so y_idx simply increments from 0.
- Reset mid-frame: outputs drop to their reset values immediately; processing resumes in passthrough until the next VSYNC fall loads config.

Decomposition:
- Shared package scanline_pkg:
  - bit-offset/width localparams for every sl_config/sl_config2 field;
  - a struct type for the shadowed config.
- Sub-module sl_blend: one channel's 2-stage multiply/truncate pipeline, instantiated three times for R, G and B.

Test Plan:
- Passthrough: reset, then a frame with all config 0 and ramp pixels -> outputs equal inputs delayed 3 cycles; syncs aligned.
- Horizontal scanlines: SL_H_EN=1, SL_VPER_M1=1, SL_HMASK=0x02, SL_STR=128, input 0xC8 -> active lines 0,2,4 output 0xC8; lines 1,3,5 output 0x64.
- Full strength vertical mask: SL_V_EN=1, SL_HPER_M1=2, SL_VMASK=0x04, SL_STR=255, input 0xFF -> columns 2,5,8 output 0x00; others 0xFF.
- Config tearing: change SL_STR from 0 to 128 mid-frame -> no change until the next VSYNC falling edge; the frame after shows 0x64 from 0xC8.
- Edge coincidence: VSYNC fall and DE rise on the same cycle -> that line uses y_idx=0 with the old config; the next line uses y_idx=1 with the new config.
- Async reset asserted mid-line -> DE_o=0, HSYNC_o=VSYNC_o=1, RGB=0 immediately without a clock; after release, passthrough holds until the next VSYNC fall.

Source files
------------

// File: rtl/scanline_pkg.sv
// Shared field layout of the sl_config / sl_config2 words and the shadowed
// scanline configuration type.
package scanline_pkg;

    localparam int SL_STR_LSB   = 0;
    localparam int SL_STR_W     = 8;
    localparam int SL_HMASK_LSB = 8;
    localparam int SL_HMASK_W   = 8;
    localparam int SL_VPER_LSB  = 16;
    localparam int SL_VPER_W    = 3;
    localparam int SL_HEN_BIT   = 19;
    localparam int SL_VEN_BIT   = 20;
    localparam int SL_VMASK_LSB = 0;
    localparam int SL_VMASK_W   = 8;
    localparam int SL_HPER_LSB  = 8;
    localparam int SL_HPER_W    = 3;

    typedef struct packed {
        logic [SL_STR_W-1:0]   str;
        logic [SL_HMASK_W-1:0] hmask;
        logic [SL_VPER_W-1:0]  vper_m1;
        logic                  h_en;
        logic                  v_en;
        logic [SL_VMASK_W-1:0] vmask;
        logic [SL_HPER_W-1:0]  hper_m1;
    } sl_cfg_t;

    function automatic sl_cfg_t unpack_cfg(input logic [31:0] cfg1, input logic [31:0] cfg2);
        sl_cfg_t c;
        c.str     = cfg1[SL_STR_LSB +: SL_STR_W];
        c.hmask   = cfg1[SL_HMASK_LSB +: SL_HMASK_W];
        c.vper_m1 = cfg1[SL_VPER_LSB +: SL_VPER_W];
        c.h_en    = cfg1[SL_HEN_BIT];
        c.v_en    = cfg1[SL_VEN_BIT];
        c.vmask   = cfg2[SL_VMASK_LSB +: SL_VMASK_W];
        c.hper_m1 = cfg2[SL_HPER_LSB +: SL_HPER_W];
        return c;
    endfunction

endpackage

// File: rtl/scanline_proc_blend.sv
// One colour channel's blend: registered multiply by the darkening factor,
// then a registered truncation back to the pixel width.
module sl_blend #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] pix,
    input  logic         on,
    input  logic [W-1:0] str,
    output logic [W-1:0] res
);

    localparam logic [W:0] UNITY = {1'b1, {W{1'b0}}};

    logic [W:0]   factor;
    logic [2*W:0] prod_full;
    logic [2*W:0] prod;
    logic         unused_bits;

    assign factor      = on ? (UNITY - {1'b0, str}) : UNITY;
    assign prod_full   = {{(W+1){1'b0}}, pix} * {{W{1'b0}}, factor};
    // The product never exceeds 2*W bits, and the low byte is dropped by design.
    assign unused_bits = ^{prod[2*W], prod[W-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod <= '0;
            res  <= '0;
        end else begin
            prod <= prod_full;
            res  <= prod[2*W-1:W];
        end
    end

endmodule

// File: rtl/scanline_proc.sv
// CRT scanline / aperture-mask post-processor with frame-shadowed config and
// a fixed three-cycle pipeline for pixels and syncs alike.
module scanline_proc
    import scanline_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic             PCLK_i,
    input  logic             reset_n,
    input  logic [PIX_W-1:0] R_i,
    input  logic [PIX_W-1:0] G_i,
    input  logic [PIX_W-1:0] B_i,
    input  logic             HSYNC_i,
    input  logic             VSYNC_i,
    input  logic             DE_i,
    input  logic [31:0]      sl_config,
    input  logic [31:0]      sl_config2,
    output logic [PIX_W-1:0] R_o,
    output logic [PIX_W-1:0] G_o,
    output logic [PIX_W-1:0] B_o,
    output logic             HSYNC_o,
    output logic             VSYNC_o,
    output logic             DE_o
);

    sl_cfg_t          shadow;
    logic             vsync_prev;
    logic             de_prev;
    logic             first_line;
    logic [2:0]       y_idx;
    logic [2:0]       x_idx;
    logic [2:0]       y_eff;
    logic [2:0]       x_eff;
    logic             vsync_fall;
    logic             de_rise;
    logic             sl_on;
    logic [PIX_W-1:0] str_s1;
    logic [PIX_W-1:0] r_s1;
    logic [PIX_W-1:0] g_s1;
    logic [PIX_W-1:0] b_s1;
    logic [2:0]       hs_pipe;
    logic [2:0]       vs_pipe;
    logic [2:0]       de_pipe;
    logic             unused_cfg;

    assign vsync_fall = vsync_prev & ~VSYNC_i;
    assign de_rise    = DE_i & ~de_prev;
    assign unused_cfg = ^{sl_config[31:21], sl_config2[31:11]};

    // Indices that apply to the current pixel, including the DE edge pixel.
    always_comb begin
        y_eff = y_idx;
        x_eff = x_idx;
        if (de_rise) begin
            x_eff = '0;
            if (first_line || vsync_fall || (y_idx >= shadow.vper_m1))
                y_eff = '0;
            else
                y_eff = y_idx + 3'd1;
        end else if (DE_i) begin
            x_eff = (x_idx >= shadow.hper_m1) ? 3'd0 : x_idx + 3'd1;
        end
    end

    always_ff @(posedge PCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            shadow     <= '0;
            vsync_prev <= 1'b0;
            de_prev    <= 1'b0;
            first_line <= 1'b0;
            y_idx      <= '0;
            x_idx      <= '0;
        end else begin
            vsync_prev <= VSYNC_i;
            de_prev    <= DE_i;
            y_idx      <= y_eff;
            x_idx      <= x_eff;
            if (vsync_fall)
                shadow <= unpack_cfg(sl_config, sl_config2);
            // A line starting on the frame-start cycle consumes the flag at once.
            if (de_rise)
                first_line <= 1'b0;
            else if (vsync_fall)
                first_line <= 1'b1;
        end
    end

    // Stage 1: darken decision with its strength, pixels, and sync delay line.
    always_ff @(posedge PCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            sl_on   <= 1'b0;
            str_s1  <= '0;
            r_s1    <= '0;
            g_s1    <= '0;
            b_s1    <= '0;
            hs_pipe <= 3'b111;
            vs_pipe <= 3'b111;
            de_pipe <= 3'b000;
        end else begin
            sl_on   <= DE_i & ((shadow.h_en & shadow.hmask[y_eff]) |
                               (shadow.v_en & shadow.vmask[x_eff]));
            str_s1  <= shadow.str;
            r_s1    <= R_i;
            g_s1    <= G_i;
            b_s1    <= B_i;
            hs_pipe <= {hs_pipe[1:0], HSYNC_i};
            vs_pipe <= {vs_pipe[1:0], VSYNC_i};
            de_pipe <= {de_pipe[1:0], DE_i};
        end
    end

    sl_blend #(.W(PIX_W)) u_blend_r (
        .clk(PCLK_i), .rst_n(reset_n), .pix(r_s1), .on(sl_on), .str(str_s1), .res(R_o)
    );
    sl_blend #(.W(PIX_W)) u_blend_g (
        .clk(PCLK_i), .rst_n(reset_n), .pix(g_s1), .on(sl_on), .str(str_s1), .res(G_o)
    );
    sl_blend #(.W(PIX_W)) u_blend_b (
        .clk(PCLK_i), .rst_n(reset_n), .pix(b_s1), .on(sl_on), .str(str_s1), .res(B_o)
    );

    assign HSYNC_o = hs_pipe[2];
    assign VSYNC_o = vs_pipe[2];
    assign DE_o    = de_pipe[2];

endmodule

// File: tb/tb_scanline_proc.sv
// Directed bench for scanline_proc: hand-computed expectations queued per input
// cycle and compared three cycles later with immediate assertions.
module tb_scanline_proc;

    logic        PCLK_i = 1'b0;
    logic        reset_n;
    logic [7:0]  R_i, G_i, B_i;
    logic        HSYNC_i, VSYNC_i, DE_i;
    logic [31:0] sl_config, sl_config2;
    logic [7:0]  R_o, G_o, B_o;
    logic        HSYNC_o, VSYNC_o, DE_o;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [7:0] pix;
        logic       hs;
        logic       vs;
        logic       de;
    } exp_t;

    exp_t exp_q[$];

    scanline_proc #(.PIX_W(8)) dut (
        .PCLK_i(PCLK_i), .reset_n(reset_n),
        .R_i(R_i), .G_i(G_i), .B_i(B_i),
        .HSYNC_i(HSYNC_i), .VSYNC_i(VSYNC_i), .DE_i(DE_i),
        .sl_config(sl_config), .sl_config2(sl_config2),
        .R_o(R_o), .G_o(G_o), .B_o(B_o),
        .HSYNC_o(HSYNC_o), .VSYNC_o(VSYNC_o), .DE_o(DE_o)
    );

    always #5 PCLK_i = ~PCLK_i;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic check_output(input exp_t e);
        check8("R_o", R_o, e.pix);
        check8("G_o", G_o, e.pix);
        check8("B_o", B_o, e.pix);
        check1("HSYNC_o", HSYNC_o, e.hs);
        check1("VSYNC_o", VSYNC_o, e.vs);
        check1("DE_o", DE_o, e.de);
    endtask

    task automatic check_reset_state();
        check8("rst_R_o", R_o, 8'h00);
        check8("rst_G_o", G_o, 8'h00);
        check8("rst_B_o", B_o, 8'h00);
        check1("rst_HSYNC_o", HSYNC_o, 1'b1);
        check1("rst_VSYNC_o", VSYNC_o, 1'b1);
        check1("rst_DE_o", DE_o, 1'b0);
    endtask

    // One input cycle, driven at a falling edge; the output for the input
    // driven two calls earlier is compared at the next falling edge.
    task automatic apply_stimulus(input logic [7:0] pix, input logic hs, input logic vs,
                                  input logic de, input logic [7:0] exp_pix);
        exp_t e;
        R_i = pix; G_i = pix; B_i = pix;
        HSYNC_i = hs; VSYNC_i = vs; DE_i = de;
        e.pix = exp_pix; e.hs = hs; e.vs = vs; e.de = de;
        exp_q.push_back(e);
        @(negedge PCLK_i);
        if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            check_output(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) apply_stimulus(8'h11, 1'b1, 1'b1, 1'b0, 8'h11);
    endtask

    task automatic vsync_frame();
        apply_stimulus(8'h55, 1'b1, 1'b0, 1'b0, 8'h55);
        apply_stimulus(8'h56, 1'b1, 1'b0, 1'b0, 8'h56);
        idle(2);
    endtask

    task automatic line_start();
        apply_stimulus(8'h22, 1'b0, 1'b1, 1'b0, 8'h22);
        apply_stimulus(8'h33, 1'b1, 1'b1, 1'b0, 8'h33);
    endtask

    task automatic hline(input logic [7:0] pix, input logic [7:0] exp_pix, input int n);
        line_start();
        repeat (n) apply_stimulus(pix, 1'b1, 1'b1, 1'b1, exp_pix);
        apply_stimulus(8'h44, 1'b1, 1'b1, 1'b0, 8'h44);
    endtask

    initial begin
        reset_n = 1'b0;
        R_i = '0; G_i = '0; B_i = '0;
        HSYNC_i = 1'b1; VSYNC_i = 1'b1; DE_i = 1'b0;
        sl_config = '0; sl_config2 = '0;
        #12;
        check_reset_state();
        @(negedge PCLK_i);
        reset_n = 1'b1;

        $display("[TB] passthrough ramp");
        vsync_frame();
        for (int l = 0; l < 2; l++) begin
            line_start();
            for (int c = 0; c < 8; c++) begin
                logic [7:0] p;
                p = 8'(l * 40 + c * 17 + 3);
                apply_stimulus(p, 1'b1, 1'b1, 1'b1, p);
            end
            apply_stimulus(8'h44, 1'b1, 1'b1, 1'b0, 8'h44);
        end

        $display("[TB] horizontal scanlines");
        sl_config = 32'h0009_0280;
        vsync_frame();
        for (int l = 0; l < 6; l++)
            hline(8'hC8, (l % 2 == 1) ? 8'h64 : 8'hC8, 4);

        $display("[TB] vertical mask, full strength");
        sl_config  = 32'h0010_00FF;
        sl_config2 = 32'h0000_0204;
        vsync_frame();
        for (int l = 0; l < 2; l++) begin
            line_start();
            for (int c = 0; c < 9; c++)
                apply_stimulus(8'hFF, 1'b1, 1'b1, 1'b1, (c % 3 == 2) ? 8'h00 : 8'hFF);
            apply_stimulus(8'h44, 1'b1, 1'b1, 1'b0, 8'h44);
        end

        $display("[TB] config tearing");
        sl_config  = 32'h0008_FF00;
        sl_config2 = 32'h0000_0000;
        vsync_frame();
        hline(8'hC8, 8'hC8, 4);
        line_start();
        apply_stimulus(8'hC8, 1'b1, 1'b1, 1'b1, 8'hC8);
        sl_config = 32'h0008_FF80;
        apply_stimulus(8'hC8, 1'b1, 1'b1, 1'b1, 8'hC8);
        apply_stimulus(8'h44, 1'b1, 1'b1, 1'b0, 8'h44);
        hline(8'hC8, 8'hC8, 4);
        vsync_frame();
        hline(8'hC8, 8'h64, 4);

        $display("[TB] vsync fall coincident with DE rise");
        sl_config = 32'h0009_02C0;
        line_start();
        apply_stimulus(8'hC8, 1'b1, 1'b0, 1'b1, 8'h64);
        repeat (3) apply_stimulus(8'hC8, 1'b1, 1'b0, 1'b1, 8'hC8);
        apply_stimulus(8'h44, 1'b1, 1'b1, 1'b0, 8'h44);
        hline(8'hC8, 8'h32, 4);
        hline(8'hC8, 8'hC8, 4);

        $display("[TB] asynchronous reset mid-line");
        line_start();
        repeat (3) apply_stimulus(8'hC8, 1'b1, 1'b1, 1'b1, 8'h32);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state();
        exp_q.delete();
        HSYNC_i = 1'b1; VSYNC_i = 1'b1; DE_i = 1'b0;
        @(negedge PCLK_i);
        @(negedge PCLK_i);
        reset_n = 1'b1;
        idle(2);
        hline(8'hC8, 8'hC8, 4);
        vsync_frame();
        hline(8'hC8, 8'hC8, 4);
        hline(8'hC8, 8'h32, 4);
        idle(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
